// File: rtl/sdram_pattern_tester_if.sv
// rtl/sdram_pattern_tester_if.sv - SDRAM request/ack bus between the pattern tester (master) and sdram_top (slave)
interface sdram_pattern_tester_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  logic              sdram_init_done;
  logic              sdram_wr_req;
  logic [ADDR_W-1:0] sdram_wr_addr;
  logic [8:0]        sdwr_bytes;
  logic [DATA_W-1:0] sdram_wr_data;
  logic              sdram_wr_ack;
  logic              sdram_rd_req;
  logic [ADDR_W-1:0] sdram_rd_addr;
  logic [8:0]        sdrd_bytes;
  logic [DATA_W-1:0] sdram_rd_data;
  logic              sdram_rd_ack;

  modport master (
    input  sdram_init_done, sdram_wr_ack, sdram_rd_data, sdram_rd_ack,
    output sdram_wr_req, sdram_wr_addr, sdwr_bytes, sdram_wr_data,
           sdram_rd_req, sdram_rd_addr, sdrd_bytes
  );

  modport slave (
    output sdram_init_done, sdram_wr_ack, sdram_rd_data, sdram_rd_ack,
    input  sdram_wr_req, sdram_wr_addr, sdwr_bytes, sdram_wr_data,
           sdram_rd_req, sdram_rd_addr, sdrd_bytes
  );
endinterface

// File: rtl/sdram_pattern_tester.sv
// rtl/sdram_pattern_tester.sv - bursted write/read-back SDRAM pattern self-test engine
// Optional SDRAM_TESTER_LOOP_EN: run passes back to back until start is pulsed while busy.
module sdram_pattern_tester #(
  parameter int                ADDR_W     = 24,
  parameter int                DATA_W     = 16,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter int                ADDR_COUNT = 1024,
  parameter int                BURST_LEN  = 8,
  parameter int                ERR_W      = 16
) (
  input  logic                   clk_100m,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             mode,
  sdram_pattern_tester_if.master sdram,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ERR_W-1:0]       err_count,
  output logic [ADDR_W-1:0]      first_err_addr,
  output logic [DATA_W-1:0]      last_rd_data,
  output logic [7:0]             pass_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_XFER, S_RD_REQ, S_RD_XFER, S_CHECK_END
  } state_t;

  state_t            state, state_n;
  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] burst_addr;
  logic [8:0]        burst_len;
  logic [8:0]        burst_cnt;
  logic [31:0]       remaining;
  logic [31:0]       rem_after;
  logic [ADDR_W-1:0] word_addr;
  logic [DATA_W-1:0] exp_word;
  logic              cmp_valid;
  logic [DATA_W-1:0] cmp_data;
  logic [DATA_W-1:0] cmp_exp;
  logic [ADDR_W-1:0] cmp_addr;
  logic              wr_take, rd_take, xfer_end, start_ok;
  logic              wr_req, rd_req;
`ifdef SDRAM_TESTER_LOOP_EN
  logic              stop_req;
`endif

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                input logic [1:0] m, input logic [7:0] p);
    logic [DATA_W-1:0] v;
    v = '0;
    case (m)
      2'd0: v = DATA_W'(a) + DATA_W'(p);
      2'd1: v = DATA_W'(a);
      2'd2: v = DATA_W'(1) << (a % ADDR_W'(DATA_W));
      default: for (int i = 0; i < DATA_W; i++) v[i] = a[0] ? (i % 2 == 1) : (i % 2 == 0);
    endcase
    return p[0] ? ~v : v;
  endfunction

  function automatic logic [8:0] calc_len(input logic [31:0] rem);
    if (rem < 32'(BURST_LEN)) return rem[8:0];
    return 9'(BURST_LEN);
  endfunction

  assign word_addr = burst_addr + ADDR_W'(burst_cnt);
  assign exp_word  = pattern(word_addr, mode_q, pass_count);
  assign rem_after = remaining - 32'(burst_len);
  assign start_ok  = (state == S_IDLE) && start && sdram.sdram_init_done;
  // The first ack of a burst lands while still in REQ; it is word 0 of that burst.
  assign wr_take   = sdram.sdram_wr_ack && ((state == S_WR_REQ) ||
                     ((state == S_WR_XFER) && (burst_cnt < burst_len)));
  assign rd_take   = sdram.sdram_rd_ack && ((state == S_RD_REQ) ||
                     ((state == S_RD_XFER) && (burst_cnt < burst_len)));
  assign xfer_end  = ((state == S_WR_XFER) || (state == S_RD_XFER)) && (burst_cnt == burst_len);

  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    wr_req  = 1'b0;
    rd_req  = 1'b0;
    case (state)
      S_IDLE:      if (start_ok) state_n = S_WR_REQ;
      S_WR_REQ: begin
        wr_req = sdram.sdram_init_done;
        if (wr_take) state_n = S_WR_XFER;
      end
      S_WR_XFER:   if (xfer_end) state_n = (rem_after == 32'd0) ? S_RD_REQ : S_WR_REQ;
      S_RD_REQ: begin
        rd_req = sdram.sdram_init_done;
        if (rd_take) state_n = S_RD_XFER;
      end
      S_RD_XFER:   if (xfer_end) state_n = (rem_after == 32'd0) ? S_CHECK_END : S_RD_REQ;
      S_CHECK_END: begin
`ifdef SDRAM_TESTER_LOOP_EN
        state_n = stop_req ? S_IDLE : S_WR_REQ;
`else
        state_n = S_IDLE;
`endif
      end
      default:     state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      mode_q         <= '0;
      burst_addr     <= '0;
      burst_len      <= '0;
      burst_cnt      <= '0;
      remaining      <= '0;
      cmp_valid      <= 1'b0;
      cmp_data       <= '0;
      cmp_exp        <= '0;
      cmp_addr       <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      last_rd_data   <= '0;
      pass_count     <= '0;
`ifdef SDRAM_TESTER_LOOP_EN
      stop_req       <= 1'b0;
`endif
    end else begin
      cmp_valid <= 1'b0;
`ifdef SDRAM_TESTER_LOOP_EN
      done <= 1'b0;
      if (start && busy) stop_req <= 1'b1;
`endif
      if (start_ok) begin
        mode_q         <= mode;
        err_count      <= '0;
        first_err_addr <= '0;
        done           <= 1'b0;
        pass           <= 1'b0;
        burst_addr     <= START_ADDR;
        remaining      <= 32'(ADDR_COUNT);
        burst_len      <= calc_len(32'(ADDR_COUNT));
        burst_cnt      <= '0;
`ifdef SDRAM_TESTER_LOOP_EN
        stop_req       <= 1'b0;
`endif
      end
      if (wr_take || rd_take) burst_cnt <= burst_cnt + 9'd1;
      if (rd_take) begin
        cmp_valid    <= 1'b1;
        cmp_data     <= sdram.sdram_rd_data;
        cmp_exp      <= exp_word;
        cmp_addr     <= word_addr;
        last_rd_data <= sdram.sdram_rd_data;
      end
      // End of a phase rewinds the range so the next phase (or next loop pass) starts clean.
      if (xfer_end) begin
        burst_cnt <= '0;
        if (rem_after == 32'd0) begin
          burst_addr <= START_ADDR;
          remaining  <= 32'(ADDR_COUNT);
          burst_len  <= calc_len(32'(ADDR_COUNT));
        end else begin
          burst_addr <= burst_addr + ADDR_W'(burst_len);
          remaining  <= rem_after;
          burst_len  <= calc_len(rem_after);
        end
      end
      if (cmp_valid && (cmp_data != cmp_exp)) begin
        if (err_count == '0) first_err_addr <= cmp_addr;
        if (err_count != '1) err_count <= err_count + 1'b1;
      end
      if (state == S_CHECK_END) begin
        pass_count <= pass_count + 8'd1;
        done       <= 1'b1;
        pass       <= (err_count == '0);
      end
    end
  end

  assign busy                = (state != S_IDLE);
  assign sdram.sdram_wr_req  = wr_req;
  assign sdram.sdram_rd_req  = rd_req;
  assign sdram.sdram_wr_addr = burst_addr;
  assign sdram.sdram_rd_addr = burst_addr;
  assign sdram.sdwr_bytes    = burst_len;
  assign sdram.sdrd_bytes    = burst_len;
  assign sdram.sdram_wr_data = ((state == S_WR_REQ) || (state == S_WR_XFER)) ? exp_word : '0;

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// tb/tb_sdram_pattern_tester.sv - directed vector bench for sdram_pattern_tester with a small SDRAM model
module tb_sdram_pattern_tester;

  localparam int N = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [23:0] first_err_addr;
  logic [15:0] last_rd_data;
  logic [7:0]  pass_count;

  int checks = 0;
  int errors = 0;
  bit corrupt = 0;
  logic [15:0] mem [0:31];
  int wr_addrs[$], wr_lens[$], rd_addrs[$], rd_lens[$];

  sdram_pattern_tester_if #(.ADDR_W(24), .DATA_W(16)) bus ();

  sdram_pattern_tester #(
    .ADDR_W(24), .DATA_W(16), .START_ADDR(24'h0),
    .ADDR_COUNT(N), .BURST_LEN(4), .ERR_W(16)
  ) dut (
    .clk_100m(clk), .rst(rst), .start(start), .mode(mode), .sdram(bus.master),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .last_rd_data(last_rd_data), .pass_count(pass_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    bit         corrupt;
    bit         midstart;
    bit         drop;
    int         exp_err;
    int         exp_first;
    bit         exp_pass;
  } vec_t;

  function automatic logic [15:0] exp_pat(int a, int m, int p);
    logic [15:0] v;
    case (m)
      0:       v = 16'(a + p);
      1:       v = 16'(a);
      2:       v = 16'h0001 << (a % 16);
      default: v = (a % 2 == 1) ? 16'hAAAA : 16'h5555;
    endcase
    return (p % 2 == 1) ? ~v : v;
  endfunction

  function automatic logic [15:0] corrupt_mask(int a);
    return (corrupt && (a == 5 || a == 9)) ? 16'h0001 : 16'h0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SDRAM model: one idle cycle after a request, then one ack per word back to back.
  initial begin : model
    int a, n;
    bus.sdram_wr_ack  = 1'b0;
    bus.sdram_rd_ack  = 1'b0;
    bus.sdram_rd_data = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.sdram_wr_req) begin
        a = int'(bus.sdram_wr_addr); n = int'(bus.sdwr_bytes);
        wr_addrs.push_back(a); wr_lens.push_back(n);
        @(negedge clk);
        for (int i = 0; i < n && !rst; i++) begin
          bus.sdram_wr_ack = 1'b1;
          mem[(a + i) % 32] = bus.sdram_wr_data;
          @(negedge clk);
        end
        bus.sdram_wr_ack = 1'b0;
      end else if (!rst && bus.sdram_rd_req) begin
        a = int'(bus.sdram_rd_addr); n = int'(bus.sdrd_bytes);
        rd_addrs.push_back(a); rd_lens.push_back(n);
        @(negedge clk);
        for (int i = 0; i < n && !rst; i++) begin
          bus.sdram_rd_ack  = 1'b1;
          bus.sdram_rd_data = mem[(a + i) % 32] ^ corrupt_mask(a + i);
          @(negedge clk);
        end
        bus.sdram_rd_ack  = 1'b0;
        bus.sdram_rd_data = '0;
      end
    end
  end

  task automatic run_test(input logic [1:0] m, input bit midstart, input bit drop);
    bit ok;
    wr_addrs.delete(); wr_lens.delete(); rd_addrs.delete(); rd_lens.delete();
    for (int a = 0; a < 32; a++) mem[a] = 16'hDEAD;
    @(negedge clk); mode = m; start = 1'b1;
    @(negedge clk); start = 1'b0;
    ok = 0;
    for (int c = 0; c < 2000; c++) begin
      start = (midstart && c == 30);
      if (drop && c == 15) bus.sdram_init_done = 1'b0;
      if (drop && c == 40) bus.sdram_init_done = 1'b1;
      if (done && !busy) begin ok = 1; break; end
      @(negedge clk);
    end
    start = 1'b0;
    bus.sdram_init_done = 1'b1;
    check("run_complete", ok, 1);
  endtask

  task automatic check_mem(input string name, input int m, input int p);
    int bad = 0;
    for (int a = 0; a < N; a++) if (mem[a] !== exp_pat(a, m, p)) bad++;
    check(name, bad, 0);
  endtask

  initial begin : main
    vec_t vecs[5];
    int   exp_addr[3];
    int   exp_len[3];
    int   pcount;
    bit   got;
    vecs[0] = '{2'd1, 0, 0, 0, 0, 0, 1};
    vecs[1] = '{2'd0, 1, 1, 0, 2, 5, 0};
    vecs[2] = '{2'd2, 0, 0, 1, 0, 0, 1};
    vecs[3] = '{2'd3, 1, 0, 0, 2, 5, 0};
    vecs[4] = '{2'd0, 0, 0, 0, 0, 0, 1};
    exp_addr = '{0, 4, 8};
    exp_len  = '{4, 4, 2};

    rst = 1'b1; start = 1'b0; mode = 2'd0; bus.sdram_init_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err_count", err_count, 0);
    check("rst_first_err_addr", first_err_addr, 0);
    check("rst_pass_count", pass_count, 0);
    check("rst_reqs", {bus.sdram_wr_req, bus.sdram_rd_req}, 0);
    check("rst_wr_data", bus.sdram_wr_data, 0);
    rst = 1'b0;

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    check("no_init_idle", busy, 0);
    check("no_init_no_req", bus.sdram_wr_req, 0);
    bus.sdram_init_done = 1'b1;

`ifdef SDRAM_TESTER_LOOP_EN
    begin
      int dones = 0, inv_bad = 0;
      bit ok = 0;
      @(negedge clk); mode = 2'd0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int c = 0; c < 5000; c++) begin
        @(negedge clk);
        start = 1'b0;
        if (done) begin
          dones++;
          if (dones == 2) begin
            for (int a = 0; a < N; a++) if (mem[a] !== ~16'(a + 1)) inv_bad++;
            start = 1'b1;
          end
        end
        if (!busy) begin ok = 1; break; end
      end
      start = 1'b0;
      check("loop_stopped", ok, 1);
      check("loop_done_pulses", dones, 3);
      check("loop_pass_count", pass_count, 3);
      check("loop_err_count", err_count, 0);
      check("loop_pass", pass, 1);
      check("loop_odd_pass_inverted", inv_bad, 0);
      check_mem("loop_last_pass_data", 0, 2);
    end
`else
    pcount = 0;
    for (int i = 0; i < 5; i++) begin
      corrupt = vecs[i].corrupt;
      run_test(vecs[i].mode, vecs[i].midstart, vecs[i].drop);
      check($sformatf("v%0d_done", i), done, 1);
      check($sformatf("v%0d_busy", i), busy, 0);
      check($sformatf("v%0d_pass", i), pass, vecs[i].exp_pass);
      check($sformatf("v%0d_err_count", i), err_count, vecs[i].exp_err);
      check($sformatf("v%0d_first_err_addr", i), first_err_addr, vecs[i].exp_first);
      check($sformatf("v%0d_pass_count", i), pass_count, pcount + 1);
      check($sformatf("v%0d_last_rd_data", i), last_rd_data,
            exp_pat(9, vecs[i].mode, pcount) ^ corrupt_mask(9));
      check_mem($sformatf("v%0d_mem_pattern", i), vecs[i].mode, pcount);
      if (i == 0) begin
        check("wr_burst_count", wr_lens.size(), 3);
        check("rd_burst_count", rd_lens.size(), 3);
        for (int b = 0; b < 3; b++) begin
          check($sformatf("wr_addr%0d", b), wr_addrs[b], exp_addr[b]);
          check($sformatf("wr_len%0d", b), wr_lens[b], exp_len[b]);
          check($sformatf("rd_addr%0d", b), rd_addrs[b], exp_addr[b]);
          check($sformatf("rd_len%0d", b), rd_lens[b], exp_len[b]);
        end
      end
      pcount++;
    end
    corrupt = 0;

    @(negedge clk); mode = 2'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    got = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.sdram_wr_ack) begin got = 1; break; end
    end
    check("reset_reached_wr_ack", got, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst_wr_req", bus.sdram_wr_req, 0);
    check("async_rst_rd_req", bus.sdram_rd_req, 0);
    check("async_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_test(2'd1, 0, 0);
    check("post_rst_pass", pass, 1);
    check("post_rst_err_count", err_count, 0);
    check("post_rst_pass_count", pass_count, 1);
    check_mem("post_rst_mem_pattern", 1, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
